// File: rtl/mips_pkg.sv
// Types and helpers shared by the memory bridge and the control decoder:
// opcode and bridge-state enums, access-size decode and store-lane steering.
package mips_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = WORD_W / 8;

    typedef enum logic [5:0] {
        OP_LB  = 6'h20,
        OP_LH  = 6'h21,
        OP_LWL = 6'h22,
        OP_LW  = 6'h23,
        OP_LBU = 6'h24,
        OP_LHU = 6'h25,
        OP_LWR = 6'h26,
        OP_SB  = 6'h28,
        OP_SH  = 6'h29,
        OP_SW  = 6'h2b
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_DATA,
        ST_DONE
    } bridge_state_e;

    // SZ_PART covers LWL/LWR, which accept any byte offset.
    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD,
        SZ_PART
    } access_size_e;

    typedef struct packed {
        logic [LANES-1:0]  byteenable;
        logic [WORD_W-1:0] writedata;
    } bus_wr_t;

    function automatic access_size_e access_size(input logic [5:0] op, input logic is_write);
        access_size_e sz;
        sz = SZ_WORD;
        if (is_write) begin
            case (op)
                OP_SB:   sz = SZ_BYTE;
                OP_SH:   sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (op)
                OP_LB, OP_LBU:   sz = SZ_BYTE;
                OP_LH, OP_LHU:   sz = SZ_HALF;
                OP_LWL, OP_LWR:  sz = SZ_PART;
                default:         sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

    function automatic logic is_aligned(input access_size_e sz, input logic [1:0] k);
        logic ok;
        case (sz)
            SZ_WORD: ok = (k == 2'b00);
            SZ_HALF: ok = ~k[0];
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [LANES-1:0] store_lanes(input access_size_e sz, input logic [1:0] k);
        logic [LANES-1:0] be;
        case (sz)
            SZ_BYTE: be = LANES'(1) << k;
            SZ_HALF: be = k[1] ? 4'b1100 : 4'b0011;
            default: be = '1;
        endcase
        return be;
    endfunction

    // Narrow stores replicate the datum so every enabled lane sees it.
    function automatic logic [WORD_W-1:0] store_data(input access_size_e sz, input logic [WORD_W-1:0] wd);
        logic [WORD_W-1:0] d;
        case (sz)
            SZ_BYTE: d = {LANES{wd[7:0]}};
            SZ_HALF: d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data shaping: lane extraction, sign/zero extension and
// the LWL/LWR merge with the old rt value.
module load_extend
    import mips_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic [1:0]        k_i,
    input  logic [5:0]        opcode_i,
    input  logic [WORD_W-1:0] rt_old_i,
    output logic [WORD_W-1:0] result_c
);

    localparam logic [WORD_W-1:0] ALL_ONES = '1;

    logic [4:0]        lane_sh;
    logic [4:0]        lwl_sh;
    logic [WORD_W-1:0] shifted;
    logic [WORD_W-1:0] lwl_mask;
    logic [WORD_W-1:0] lwr_mask;

    assign lane_sh  = {k_i, 3'b000};
    // 3-k on two bits is simply ~k.
    assign lwl_sh   = {~k_i, 3'b000};
    assign shifted  = word_i >> lane_sh;
    // Two-step shift so k=3 clears the mask instead of overflowing the amount.
    assign lwl_mask = (ALL_ONES >> lane_sh) >> 8;
    assign lwr_mask = ~(ALL_ONES >> lane_sh);

    always_comb begin
        result_c = word_i;
        case (opcode_i)
            OP_LB:   result_c = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  result_c = {24'b0, shifted[7:0]};
            OP_LH:   result_c = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  result_c = {16'b0, shifted[15:0]};
            OP_LWL:  result_c = (word_i << lwl_sh) | (rt_old_i & lwl_mask);
            OP_LWR:  result_c = shifted | (rt_old_i & lwr_mask);
            default: result_c = word_i;
        endcase
    end

endmodule

// File: rtl/mem_bus_bridge.sv
// Bridge from the multicycle CPU's MemRead/MemWrite strobes to a word-aligned
// Avalon-MM master with waitrequest stalling, lane steering and load shaping.
module mem_bus_bridge
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [5:0]            opcode,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W-1:0]     rt_old,
    output logic [ADDR_W-1:0]     address,
    output logic                  read,
    output logic                  write,
    output logic [DATA_W/8-1:0]   byteenable,
    output logic [DATA_W-1:0]     writedata,
    input  logic                  waitrequest,
    input  logic [DATA_W-1:0]     readdata,
    output logic [DATA_W-1:0]     rdata,
    output logic                  stall,
    output logic                  done,
    output logic                  misaligned
);

    bridge_state_e state_q, state_d;

    logic [ADDR_W-1:0] address_q, address_d;
    bus_wr_t           cmd_q, cmd_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              mis_q, mis_d;
    logic [5:0]        op_q, op_d;
    logic [1:0]        k_q, k_d;
    logic [DATA_W-1:0] rt_q, rt_d;

    logic              req_any;
    logic              req_both;
    logic              req_ok;
    logic              req_reject;
    logic [1:0]        req_k;
    access_size_e      req_size;
    logic [DATA_W-1:0] ext_word;

    // Request decode, only meaningful while IDLE.
    assign req_any    = mem_read | mem_write;
    assign req_both   = mem_read & mem_write;
    assign req_k      = addr[1:0];
    assign req_size   = access_size(opcode, mem_write);
    assign req_ok     = req_any & ~req_both & is_aligned(req_size, req_k);
    assign req_reject = req_any & ~req_ok;

    load_extend u_load_extend (
        .word_i   (readdata),
        .k_i      (k_q),
        .opcode_i (op_q),
        .rt_old_i (rt_q),
        .result_c (ext_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_ok) begin
                    state_d = ST_BUS;
                end else if (req_reject) begin
                    state_d = ST_DONE;
                end
            end
            ST_BUS: begin
                if (!waitrequest) begin
                    state_d = write_q ? ST_DONE : ST_DATA;
                end
            end
            ST_DATA: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and the latched request context.
    always_comb begin
        address_d = address_q;
        cmd_d     = cmd_q;
        read_d    = read_q;
        write_d   = write_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        mis_d     = 1'b0;
        op_d      = op_q;
        k_d       = k_q;
        rt_d      = rt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_ok) begin
                    address_d = {addr[ADDR_W-1:2], 2'b00};
                    read_d    = mem_read;
                    write_d   = mem_write;
                    op_d      = opcode;
                    k_d       = req_k;
                    rt_d      = rt_old;
                    if (mem_write) begin
                        cmd_d.byteenable = store_lanes(req_size, req_k);
                        cmd_d.writedata  = store_data(req_size, wdata);
                    end else begin
                        cmd_d.byteenable = '1;
                    end
                end else if (req_reject) begin
                    done_d = 1'b1;
                    mis_d  = 1'b1;
                end
            end
            ST_BUS: begin
                if (!waitrequest) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    done_d  = write_q;
                end
            end
            ST_DATA: begin
                rdata_d = ext_word;
                done_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            address_q <= '0;
            cmd_q     <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            mis_q     <= 1'b0;
            op_q      <= '0;
            k_q       <= '0;
            rt_q      <= '0;
        end else begin
            address_q <= address_d;
            cmd_q     <= cmd_d;
            read_q    <= read_d;
            write_q   <= write_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            mis_q     <= mis_d;
            op_q      <= op_d;
            k_q       <= k_d;
            rt_q      <= rt_d;
        end
    end

    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign byteenable = cmd_q.byteenable;
    assign writedata  = cmd_q.writedata;
    assign rdata      = rdata_q;
    assign done       = done_q;
    assign misaligned = mis_q;
    assign stall      = ((state_q == ST_IDLE) & req_any) | (state_q == ST_BUS) | (state_q == ST_DATA);

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Randomized self-checking bench for mem_bus_bridge: a transaction-level model
// drives per-cycle expectations that a negedge monitor compares against the DUT.
module tb_mem_bus_bridge;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LWL = 6'h22;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LWR = 6'h26;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  opcode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rt_old;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        misaligned;

    always #5 clk = ~clk;

    mem_bus_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .opcode      (opcode),
        .addr        (addr),
        .wdata       (wdata),
        .rt_old      (rt_old),
        .address     (address),
        .read        (read),
        .write       (write),
        .byteenable  (byteenable),
        .writedata   (writedata),
        .waitrequest (waitrequest),
        .readdata    (readdata),
        .rdata       (rdata),
        .stall       (stall),
        .done        (done),
        .misaligned  (misaligned)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Expected DUT outputs for the current cycle.
    logic        chk_en = 1'b0;
    logic        exp_read, exp_write, exp_done, exp_mis, exp_stall;
    logic [31:0] exp_addr, exp_wd, exp_rdata;
    logic [3:0]  exp_be;

    // Per-transaction observations for literal checks.
    int          done_cyc, bus_cyc;
    logic        cap_mis;
    logic [31:0] cap_addr, cap_wd;
    logic [3:0]  cap_be;

    logic [5:0] op_pool [12] = '{OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU,
                                 OP_LWR, OP_SB, OP_SH, OP_SW, 6'h00, 6'h0f};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("read",       32'(read),       32'(exp_read));
            check("write",      32'(write),      32'(exp_write));
            check("done",       32'(done),       32'(exp_done));
            check("misaligned", 32'(misaligned), 32'(exp_mis));
            check("stall",      32'(stall),      32'(exp_stall));
            check("rdata",      rdata,           exp_rdata);
            if (exp_read || exp_write) begin
                check("address",    address,          exp_addr);
                check("byteenable", 32'(byteenable),  32'(exp_be));
            end
            if (exp_write) check("writedata", writedata, exp_wd);
        end
    end

    function automatic logic [31:0] model_load(input logic [5:0] op, input int k,
                                               input logic [31:0] word, input logic [31:0] rt);
        logic [31:0] b, h;
        b = (word >> (8 * k)) & 32'h0000_00FF;
        h = (word >> (8 * k)) & 32'h0000_FFFF;
        case (op)
            OP_LB:   return (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
            OP_LBU:  return b;
            OP_LH:   return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            OP_LHU:  return h;
            OP_LWL:  return (word << (8 * (3 - k))) | (rt & (32'hFFFF_FFFF >> (8 * (k + 1))));
            OP_LWR:  return (word >> (8 * k)) | (rt & ~(32'hFFFF_FFFF >> (8 * k)));
            default: return word;
        endcase
    endfunction

    function automatic bit model_legal(input logic rd, input logic wr, input logic [5:0] op, input int k);
        if (rd && wr) return 1'b0;
        if (wr) begin
            if (op == OP_SB) return 1'b1;
            if (op == OP_SH) return (k % 2) == 0;
            return k == 0;
        end
        if (op == OP_LB || op == OP_LBU || op == OP_LWL || op == OP_LWR) return 1'b1;
        if (op == OP_LH || op == OP_LHU) return (k % 2) == 0;
        return k == 0;
    endfunction

    function automatic logic [3:0] model_lanes(input logic [5:0] op, input int k);
        if (op == OP_SB) return 4'(1 << k);
        if (op == OP_SH) return (k == 0) ? 4'h3 : 4'hC;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [5:0] op, input logic [31:0] wd);
        if (op == OP_SB) return {24'b0, wd[7:0]} * 32'h0101_0101;
        if (op == OP_SH) return {16'b0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        opcode      = 6'($urandom);
        addr        = $urandom;
        wdata       = $urandom;
        rt_old      = $urandom;
        readdata    = $urandom;
        waitrequest = 1'($urandom_range(0, 1));
    endtask

    task automatic sample(input int cyc);
        #2;
        if (done && done_cyc < 0) begin
            done_cyc = cyc;
            cap_mis  = misaligned;
        end
        if ((read || write) && bus_cyc < 0) begin
            bus_cyc  = cyc;
            cap_addr = address;
            cap_be   = byteenable;
            cap_wd   = writedata;
        end
    endtask

    // One request issued at cycle 0, walked through its expected timeline.
    task automatic txn(input logic rd, input logic wr, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rt, input logic [31:0] word,
                       input int waits, input bit poke);
        int k;
        int cyc;
        bit ok;
        k        = int'(a[1:0]);
        ok       = model_legal(rd, wr, op, k);
        done_cyc = -1;
        bus_cyc  = -1;
        cap_mis  = 1'b0;
        mem_read = rd; mem_write = wr; opcode = op; addr = a; wdata = wd; rt_old = rt;
        exp_stall = 1'b1;
        sample(0);
        next_cycle(); scramble();
        mem_read = 1'b0; mem_write = 1'b0;
        if (!ok) begin
            exp_done = 1'b1; exp_mis = 1'b1; exp_stall = 1'b0;
            if (poke) begin mem_read = 1'b1; mem_write = 1'($urandom_range(0, 1)); end
            sample(1);
            next_cycle(); scramble();
            mem_read = 1'b0; mem_write = 1'b0;
            exp_done = 1'b0; exp_mis = 1'b0;
        end else begin
            exp_read = rd; exp_write = wr;
            exp_addr = {a[31:2], 2'b00};
            exp_be   = wr ? model_lanes(op, k) : 4'hF;
            if (wr) exp_wd = model_wdata(op, wd);
            for (int i = 0; i <= waits; i++) begin
                waitrequest = (i < waits);
                sample(1 + i);
                next_cycle(); scramble();
            end
            cyc = waits + 2;
            exp_read = 1'b0; exp_write = 1'b0;
            if (!wr) begin
                readdata = word;
                sample(cyc);
                next_cycle(); scramble();
                cyc++;
                exp_rdata = model_load(op, k, word, rt);
            end
            exp_done = 1'b1; exp_stall = 1'b0;
            if (poke) begin mem_read = 1'b1; mem_write = 1'($urandom_range(0, 1)); end
            sample(cyc);
            next_cycle(); scramble();
            mem_read = 1'b0; mem_write = 1'b0;
            exp_done = 1'b0;
        end
    endtask

    task automatic set_reset_expect();
        exp_read = 1'b0; exp_write = 1'b0; exp_done = 1'b0; exp_mis = 1'b0; exp_stall = 1'b0;
        exp_addr = '0; exp_be = '0; exp_wd = '0; exp_rdata = '0;
    endtask

    // Reset lands while a read is stalled on the bus.
    task automatic reset_mid();
        done_cyc = -1;
        bus_cyc  = -1;
        mem_read = 1'b1; mem_write = 1'b0; opcode = OP_LW; addr = 32'h0000_5008;
        exp_stall = 1'b1;
        next_cycle(); scramble();
        mem_read = 1'b0; waitrequest = 1'b1;
        exp_read = 1'b1; exp_addr = 32'h0000_5008; exp_be = 4'hF;
        next_cycle(); scramble();
        waitrequest = 1'b1;
        reset = 1'b1;
        next_cycle(); scramble();
        reset = 1'b0; waitrequest = 1'b1;
        set_reset_expect();
        sample(3);
        check("rst_mid_read", 32'(read), 32'h0);
        check("rst_mid_stall", 32'(stall), 32'h0);
        for (int i = 4; i < 7; i++) begin
            next_cycle(); scramble();
            sample(i);
        end
        check("rst_mid_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
    endtask

    initial begin
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        opcode = '0; addr = '0; wdata = '0; rt_old = '0; waitrequest = 1'b0; readdata = '0;
        set_reset_expect();
        @(posedge clk); #1;
        chk_en = 1'b1;
        next_cycle();
        reset = 1'b0;
        check("rst_read", 32'(read), 32'h0);
        check("rst_address", address, 32'h0);
        check("rst_byteenable", 32'(byteenable), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_done", 32'(done), 32'h0);

        txn(1'b1, 1'b0, OP_LW, 32'h0000_1004, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
        check("lw_rdata", rdata, 32'hDEAD_BEEF);
        check("lw_address", cap_addr, 32'h0000_1004);
        check("lw_read_cycle", 32'(bus_cyc), 32'd1);
        check("lw_done_cycle", 32'(done_cyc), 32'd3);

        txn(1'b1, 1'b0, OP_LB, 32'h0000_1003, 32'h0, 32'h0, 32'h80FF_0000, 1, 1'b0);
        check("lb_rdata", rdata, 32'hFFFF_FF80);
        txn(1'b1, 1'b0, OP_LBU, 32'h0000_1003, 32'h0, 32'h0, 32'h80FF_0000, 0, 1'b0);
        check("lbu_rdata", rdata, 32'h0000_0080);
        txn(1'b1, 1'b0, OP_LH, 32'h0000_1002, 32'h0, 32'h0, 32'h80FF_0000, 0, 1'b1);
        check("lh_rdata", rdata, 32'hFFFF_80FF);

        txn(1'b0, 1'b1, OP_SB, 32'h0000_2001, 32'h0000_00AB, 32'h0, 32'h0, 3, 1'b0);
        check("sb_byteenable", 32'(cap_be), 32'h2);
        check("sb_writedata", cap_wd, 32'hABAB_ABAB);
        check("sb_write_cycle", 32'(bus_cyc), 32'd1);
        check("sb_done_cycle", 32'(done_cyc), 32'd5);

        txn(1'b1, 1'b0, OP_LWL, 32'h0000_3001, 32'h0, 32'hAAAA_AAAA, 32'h4433_2211, 0, 1'b0);
        check("lwl_rdata", rdata, 32'h2211_AAAA);
        txn(1'b1, 1'b0, OP_LWR, 32'h0000_3002, 32'h0, 32'hAAAA_AAAA, 32'h4433_2211, 2, 1'b0);
        check("lwr_rdata", rdata, 32'hAAAA_4433);

        txn(1'b1, 1'b0, OP_LW, 32'h0000_1002, 32'h0, 32'h0, 32'h1234_5678, 0, 1'b0);
        check("lw_mis_done_cycle", 32'(done_cyc), 32'd1);
        check("lw_mis_flag", 32'(cap_mis), 32'h1);
        check("lw_mis_no_bus", 32'(bus_cyc), 32'hFFFF_FFFF);
        check("lw_mis_rdata_kept", rdata, 32'hAAAA_4433);
        txn(1'b0, 1'b1, OP_SH, 32'h0000_1001, 32'h1234_5678, 32'h0, 32'h0, 0, 1'b1);
        check("sh_mis_done_cycle", 32'(done_cyc), 32'd1);
        check("sh_mis_flag", 32'(cap_mis), 32'h1);
        check("sh_mis_no_bus", 32'(bus_cyc), 32'hFFFF_FFFF);

        reset_mid();
        txn(1'b1, 1'b0, OP_LHU, 32'h0000_4006, 32'h0, 32'h0, 32'hBEEF_0000, 1, 1'b0);
        check("post_rst_lhu", rdata, 32'h0000_BEEF);

        for (int n = 0; n < 300; n++) begin
            int sel;
            logic rd, wr;
            sel = $urandom_range(0, 19);
            rd  = (sel < 9) || (sel >= 18);
            wr  = (sel >= 9);
            txn(rd, wr, op_pool[$urandom_range(0, 11)], $urandom, $urandom, $urandom, $urandom,
                $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                next_cycle(); scramble();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_bridge.md
# mem_bus_bridge

Memory-side bridge of the multicycle MIPS CPU. It converts the control unit's one-cycle `MemRead`/`MemWrite` strobes into a word-aligned Avalon-MM master transaction with `waitrequest` stalling and byte-lane steering. It returns sign- or zero-extended, or merged, load data together with a `done` pulse. It sits between the datapath (ALUOut/PC address mux, register B, MDR) and the external memory bus.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width.
- `DATA_W`, 32, bus data width; only 32 is supported.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  load/fetch request strobe from control; sampled only in IDLE.
- `mem_write`  in  1  store request strobe from control; sampled only in IDLE.
- `opcode`  in  6  instruction opcode selecting width and extension (LW/LB/LBU/LH/LHU/LWL/LWR/SW/SB/SH); any other value is treated as a word access (instruction fetch).
- `addr`  in  32  byte address (PC or ALUOut).
- `wdata`  in  32  store data (register B).
- `rt_old`  in  32  current rt value, used by LWL/LWR merge.
- `address`  out  32  Avalon address: `{addr[31:2],2'b00}`.
- `read`  out  1  Avalon read.
- `write`  out  1  Avalon write.
- `byteenable`  out  4  Avalon byte lanes.
- `writedata`  out  32  lane-steered store data.
- `waitrequest`  in  1  Avalon stall.
- `readdata`  in  32  Avalon read data; valid the cycle after read acceptance.
- `rdata`  out  32  extended/merged load result; holds until the next request.
- `stall`  out  1  high from the request cycle until the `done` cycle exclusive.
- `done`  out  1  one-cycle completion pulse.
- `misaligned`  out  1  high with `done` when the request was rejected.

## Operation
- States: IDLE, BUS, DATA, DONE.
- IDLE→BUS on `mem_read^mem_write` with a legal alignment. Latch the address, lanes, data and type into registers.
- BUS: drive `read` or `write` from registers, holding all bus outputs stable while `waitrequest=1`. On `waitrequest=0`: a write goes →DONE; a read goes →DATA.
- DATA: capture `readdata` and apply extraction; →DONE.
- DONE: `done=1` for one cycle; →IDLE. Strobes arriving in DONE are ignored.
- Rejected request: both strobes high, LW/SW/fetch with `addr[1:0]≠0`, or LH/LHU/SH with `addr[0]=1`. This goes IDLE→DONE with `misaligned=1` and no bus cycle; `rdata` is unchanged.
- Little-endian; byte offset k=`addr[1:0]` maps to lane k (`readdata[8k+7:8k]`).
- Store lanes:
  - SW: `1111`.
  - SH: `0011` when k=0, `1100` when k=2; the halfword is replicated in both halves.
  - SB: one-hot lane k; the byte is replicated in all four lanes.
- Loads:
  - LB/LBU: lane k, sign- or zero-extended to 32.
  - LH/LHU: lanes k+1:k, sign- or zero-extended to 32.
  - LW/fetch: full word.
  - Loads use `byteenable=1111`.
- LWL, offset k: `rdata = (word << 8*(3-k)) | (rt_old & (32'hFFFFFFFF >> 8*(k+1)))`. k=3 gives the full word.
- LWR, offset k: `rdata = (word >> 8*k) | (rt_old & ~(32'hFFFFFFFF >> 8*k))`. k=0 gives the full word.
- `rt_old` is latched at the request cycle.

## Timing
- All Avalon outputs are registered.
- Reset values: `read=0`, `write=0`, `byteenable=0`, `address=0`, `writedata=0`, `rdata=0`, `done=0`, `misaligned=0`, state=IDLE.
- `stall` is combinational: `(state==IDLE & (mem_read|mem_write)) | state==BUS | state==DATA`.
- Latency with zero wait states, request at cycle 0:
  - Write: bus strobe at cycle 1, `done` at 2.
  - Read: bus strobe at 1, `readdata` sampled at the end of 2, `done` and `rdata` at 3.
  - Each cycle of `waitrequest` adds one cycle.
- Rejected request: `done` and `misaligned` at cycle 1.
- Reset mid-transaction: the next edge returns to IDLE and drops `read`/`write`. There is no `done` and no `rdata` update.

## Structure
- Shared `mips_pkg` holds the opcode enum (LB…SW) and the bridge state enum, both shared with the control decoder.
- Sub-module `load_extend` is a combinational lane extraction, extension and LWL/LWR merge, taking word, k, opcode and `rt_old`.

## Test plan
- LW at 0x1004 with `readdata=0xDEADBEEF` and no wait: `address=0x1004`, `read` at cycle 1, `done` and `rdata=0xDEADBEEF` at cycle 3.
- LB at 0x1003, word 0x80FF_0000: `rdata=0xFFFFFF80`. LBU at the same address: `rdata=0x00000080`. LH at 0x1002: `rdata=0xFFFF80FF`.
- SB at 0x2001 with `wdata=0x000000AB` and 3 cycles of `waitrequest`: `byteenable=0010`, `writedata=0xABABABAB`, outputs stable for 4 cycles, `done` at cycle 5.
- LWL at k=1 with word 0x44332211 and `rt_old=0xAAAAAAAA`: `rdata=0x2211AAAA`. LWR at k=2, same inputs: `rdata=0xAAAA4433`.
- LW at 0x1002, and SH at 0x1001: no `read`/`write`; `done=1` and `misaligned=1` at cycle 1.
- `reset` asserted while in BUS with `waitrequest=1`: `read=0` and state IDLE after one edge; no `done` pulse.
